instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'd0, meaning the PC loaded on start.
REQ-002 SHALL have parameter CORE_ID, default 0, meaning the core index (informational; selects no logic).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin fetching from RESET_PC.
REQ-006 SHALL have port im_addr, output, 16 bits: word address to this core's instruction-memory lane.
REQ-007 SHALL have port im_data, input, 16 bits: instruction-memory word, valid one clk after im_addr is sampled.
REQ-008 SHALL have port instr_valid, output, 1 bit: opcode/operand held stable for the consumer.
REQ-009 SHALL have port instr_ready, input, 1 bit: consumer accepts the instruction.
REQ-010 SHALL have port opcode, output, 16 bits: fetched opcode word.
REQ-011 SHALL have port operand, output, 16 bits: following word for operand-bearing opcodes, else 0.
REQ-012 SHALL have port has_operand, output, 1 bit: opcode is LDAC(5), JUMP(46), JPNZ(48) or JPPZ(62).
REQ-013 SHALL have ports redirect (input, 1 bit) and redirect_pc (input, 16 bits): branch-taken target from the control unit.
REQ-014 SHALL have port pc, output, 16 bits: address of the instruction currently held or being fetched.
REQ-015 SHALL have port halted, output, 1 bit: ENDOP(51) consumed; fetching stopped.

Function
REQ-016 SHALL implement FSM states IDLE, OP_REQ, OP_RSP, ARG_REQ, ARG_RSP, VALID and HALT.
REQ-017 SHALL, in IDLE, move to OP_REQ with pc=RESET_PC on start=1, and ignore redirect.
REQ-018 SHALL present im_addr=pc in OP_REQ, then in OP_RSP capture im_data into opcode.
REQ-019 SHALL, from OP_RSP, go to ARG_REQ if has_operand, else to VALID.
REQ-020 SHALL present im_addr=pc+1 (mod 2^16) in ARG_REQ, then capture im_data into operand in ARG_RSP and go to VALID.
REQ-021 SHALL give a latency from OP_REQ entry to instr_valid of 2 cycles for plain opcodes and 4 cycles for operand-bearing ones.
REQ-022 SHALL assert instr_valid only in VALID and hold opcode, operand and pc unchanged until instr_valid&&instr_ready.
REQ-023 SHALL, on acceptance, go to OP_REQ with pc += 1 (plain) or pc += 2 (operand-bearing), wrapping mod 2^16.
REQ-024 SHALL, on acceptance of ENDOP, go to HALT with halted=1 and pc unchanged; HALT exits only via reset.
REQ-025 SHALL give redirect priority over all but reset: in OP_REQ through VALID, set pc=redirect_pc, discard in-flight words, go to OP_REQ next cycle, and drop instr_valid.
REQ-026 SHALL, on redirect coincident with acceptance in VALID, consume the instruction and set pc=redirect_pc rather than the incremented value.
REQ-027 SHALL ignore redirect in HALT.

Reset
REQ-028 SHALL, on rst_n low, immediately force state=IDLE, pc=RESET_PC, im_addr=RESET_PC, opcode=0, operand=0, instr_valid=0, has_operand=0, halted=0.
REQ-029 SHALL, on reset mid-fetch, discard any response word arriving after release.

Configuration
REQ-030 SHALL, with FETCH_PERF_CNT_EN defined, add output fetch_count[31:0], reset to 0, incremented per accepted instruction, saturating at 32'hFFFFFFFF.
REQ-031 SHALL, without FETCH_PERF_CNT_EN, have no such port or counter logic.

Structure
REQ-032 SHALL take opcode constants (LDAC, JUMP, JPNZ, JPPZ, ENDOP, ...) and the FSM state encoding from shared package isa_pkg, also used by the control unit.
REQ-033 SHALL place operand classification in combinational sub-module opcode_class (opcode in, has_operand and is_end out).
REQ-034 SHALL be instantiated NUM_C times, one per instruction-memory lane.

Verification
REQ-035 SHALL cover: memory [0]=64, [1]=29, start pulse, ready=1 -> opcode 64 valid 2 cycles after OP_REQ, then 29, with pc 0 then 1.
REQ-036 SHALL cover: [2]=5, [3]=7 -> opcode=5, operand=7, has_operand=1, valid 4 cycles after OP_REQ, next pc=4.
REQ-037 SHALL cover: ready=0 for 5 cycles in VALID -> outputs stable, im_addr unchanged; accept on cycle 6 -> pc advances once.
REQ-038 SHALL cover: redirect_pc=216 during ARG_RSP -> operand discarded, next im_addr=216; [216]=51 accepted -> halted=1, pc=216, no further im_addr change.
REQ-039 SHALL cover: pc=16'hFFFF holding LDAC -> operand fetched from 16'h0000, next pc=16'h0001.
REQ-040 SHALL cover: rst_n low during OP_RSP -> all outputs immediately at reset values; start required to resume.

Source files
------------

// File: rtl/isa_pkg.sv
// isa_pkg: opcode constants and fetch FSM state encoding shared by the
// instruction fetch unit and the control unit.
package isa_pkg;

    // Opcode words recognised by the fetch unit and the control unit.
    localparam logic [15:0] OP_LDAC  = 16'd5;
    localparam logic [15:0] OP_JUMP  = 16'd46;
    localparam logic [15:0] OP_JPNZ  = 16'd48;
    localparam logic [15:0] OP_ENDOP = 16'd51;
    localparam logic [15:0] OP_JPPZ  = 16'd62;

    // Fetch FSM states. The encoding is shared so the control unit can
    // decode the debug state without a private copy.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OP_REQ  = 3'd1,
        OP_RSP  = 3'd2,
        ARG_REQ = 3'd3,
        ARG_RSP = 3'd4,
        VALID   = 3'd5,
        HALT    = 3'd6
    } fetch_state_e;

    // True for opcodes that are followed by one operand word.
    function automatic logic opcode_has_operand(input logic [15:0] op);
        return (op == OP_LDAC) || (op == OP_JUMP) ||
               (op == OP_JPNZ) || (op == OP_JPPZ);
    endfunction

    // True for the opcode that stops fetching.
    function automatic logic opcode_is_end(input logic [15:0] op);
        return (op == OP_ENDOP);
    endfunction

endpackage

// File: rtl/instr_fetch_opcode_class.sv
// opcode_class: purely combinational classification of an opcode word into
// "carries an operand word" and "ends the program".
module opcode_class
    import isa_pkg::*;
(
    input  logic [15:0] opcode,
    output logic        has_operand,
    output logic        is_end
);

    // Classify the word with the shared helper functions.
    always_comb begin
        has_operand = opcode_has_operand(opcode);
        is_end      = opcode_is_end(opcode);
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: per-lane instruction fetch unit. Reads an opcode word and,
// for operand-bearing opcodes, the following operand word from a memory
// with one cycle of read latency, then presents them to the consumer.
//
// Handshake: instr_valid is high only in VALID; opcode, operand,
// has_operand and pc stay constant while instr_valid is high and
// instr_ready is low; the instruction is consumed on the clock edge where
// instr_valid && instr_ready are both high.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_count output,
// a saturating count of accepted instructions.
module instr_fetch
    import isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'd0,
    parameter int          CORE_ID  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [15:0]  im_addr,
    input  logic [15:0]  im_data,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [15:0]  opcode,
    output logic [15:0]  operand,
    output logic         has_operand,
    input  logic         redirect,
    input  logic [15:0]  redirect_pc,
    output logic [15:0]  pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]  fetch_count,
`endif
    output fetch_state_e state_dbg,
    output logic         halted
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  opcode_q;
    logic [15:0]  operand_q;
    logic         has_op_q;
    logic         is_end_q;
    logic         cap_op;
    logic         cap_arg;
    logic         accept;
    logic         rsp_has_op;
    logic         rsp_is_end;

    // Classify the word coming back from memory so OP_RSP can branch on it.
    opcode_class u_class (
        .opcode      (im_data),
        .has_operand (rsp_has_op),
        .is_end      (rsp_is_end)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, next pc and capture strobes; redirect overrides the
    // normal flow in every active state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cap_op  = 1'b0;
        cap_arg = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = OP_REQ;
                    pc_d    = RESET_PC;
                end
            end
            OP_REQ: begin
                state_d = OP_RSP;
            end
            OP_RSP: begin
                cap_op  = 1'b1;
                state_d = rsp_has_op ? ARG_REQ : VALID;
            end
            ARG_REQ: begin
                state_d = ARG_RSP;
            end
            ARG_RSP: begin
                cap_arg = 1'b1;
                state_d = VALID;
            end
            VALID: begin
                if (instr_ready) begin
                    accept = 1'b1;
                    if (is_end_q) begin
                        state_d = HALT;
                    end else begin
                        state_d = OP_REQ;
                        pc_d    = pc_q + (has_op_q ? 16'd2 : 16'd1);
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A taken branch discards whatever is in flight; an instruction
        // accepted in the same cycle still counts as consumed.
        if (redirect && (state_q != IDLE) && (state_q != HALT)) begin
            state_d = OP_REQ;
            pc_d    = redirect_pc;
            cap_op  = 1'b0;
            cap_arg = 1'b0;
        end
    end

    // Program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Opcode/operand holding registers; the operand is cleared with every
    // new opcode so plain instructions present an operand of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q  <= 16'd0;
            operand_q <= 16'd0;
            has_op_q  <= 1'b0;
            is_end_q  <= 1'b0;
        end else begin
            if (cap_op) begin
                opcode_q  <= im_data;
                operand_q <= 16'd0;
                has_op_q  <= rsp_has_op;
                is_end_q  <= rsp_is_end;
            end
            if (cap_arg) begin
                operand_q <= im_data;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating count of accepted instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
        end else if (accept && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    logic unused_accept;
    // Acceptance only feeds the optional counter.
    always_comb begin
        unused_accept = accept;
    end
`endif

    // Output drive; the operand word address wraps naturally at 16 bits.
    always_comb begin
        im_addr     = (state_q == ARG_REQ) ? (pc_q + 16'd1) : pc_q;
        instr_valid = (state_q == VALID);
        halted      = (state_q == HALT);
        opcode      = opcode_q;
        operand     = operand_q;
        has_operand = has_op_q;
        pc          = pc_q;
        state_dbg   = state_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a one-cycle-latency
// instruction memory model and an expected queue of accepted opcodes.
module tb_instr_fetch;
    import isa_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [15:0]  im_addr;
    logic [15:0]  im_data;
    logic         instr_valid;
    logic         instr_ready;
    logic [15:0]  opcode;
    logic [15:0]  operand;
    logic         has_operand;
    logic         redirect;
    logic [15:0]  redirect_pc;
    logic [15:0]  pc;
    logic         halted;
    fetch_state_e state_dbg;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]  fetch_count;
`endif

    logic [15:0]  mem [0:65535];
    logic [15:0]  exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    instr_fetch #(.RESET_PC(16'd0), .CORE_ID(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .im_addr     (im_addr),
        .im_data     (im_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .has_operand (has_operand),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count (fetch_count),
`endif
        .state_dbg   (state_dbg),
        .halted      (halted)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: word is returned one clock after the address.
    always @(posedge clk) begin
        im_data <= mem[im_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},   32'(state_dbg),   32'(IDLE));
        check({tag, "_pc"},      32'(pc),          32'h0);
        check({tag, "_im_addr"}, 32'(im_addr),     32'h0);
        check({tag, "_opcode"},  32'(opcode),      32'h0);
        check({tag, "_operand"}, 32'(operand),     32'h0);
        check({tag, "_valid"},   32'(instr_valid), 32'h0);
        check({tag, "_has_op"},  32'(has_operand), 32'h0);
        check({tag, "_halted"},  32'(halted),      32'h0);
    endtask

    task automatic check_instr(input string tag, input logic [15:0] e_op,
                               input logic [15:0] e_arg, input logic e_has,
                               input logic [15:0] e_pc);
        check({tag, "_valid"},   32'(instr_valid), 32'h1);
        check({tag, "_opcode"},  32'(opcode),      32'(e_op));
        check({tag, "_operand"}, 32'(operand),     32'(e_arg));
        check({tag, "_has_op"},  32'(has_operand), 32'(e_has));
        check({tag, "_pc"},      32'(pc),          32'(e_pc));
    endtask

    // Scoreboard: every accepted instruction must match the head of exp_q.
    always @(negedge clk) begin
        #4;
        if (rst_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_accept", 32'(opcode), 32'hFFFF_FFFF);
            end else begin
                check("sb_accept_opcode", 32'(opcode), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[0]   = 16'd64;
        mem[1]   = 16'd29;
        mem[2]   = OP_LDAC;
        mem[3]   = 16'd7;
        mem[4]   = 16'd10;
        mem[5]   = OP_JPNZ;
        mem[6]   = 16'd1234;
        mem[216] = OP_ENDOP;
        mem[16'hFFFF] = OP_LDAC;
        exp_q = '{16'd64, 16'd29, 16'd5, 16'd10, 16'd51};

        rst_n = 1'b0;
        start = 1'b0;
        instr_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = 16'd0;

        // Reset state, then redirect ignored in IDLE.
        step(2);
        check_reset_vals("rst");
        rst_n = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'd99;
        step(1);
        check("idle_redirect_state", 32'(state_dbg), 32'(IDLE));
        check("idle_redirect_pc", 32'(pc), 32'h0);
        redirect = 1'b0;

        // Plain opcodes 64 then 29, two cycles from OP_REQ to valid.
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_state", 32'(state_dbg), 32'(OP_REQ));
        check("start_im_addr", 32'(im_addr), 32'h0);
        step(1);
        check("op64_not_yet_valid", 32'(instr_valid), 32'h0);
        step(1);
        check_instr("op64", 16'd64, 16'd0, 1'b0, 16'd0);
        step(1);
        check("op29_req_pc", 32'(pc), 32'h1);
        check("op29_req_valid", 32'(instr_valid), 32'h0);
        step(2);
        check_instr("op29", 16'd29, 16'd0, 1'b0, 16'd1);

        // LDAC with operand, four cycles from OP_REQ to valid.
        step(1);
        check("ldac_req_pc", 32'(pc), 32'h2);
        step(2);
        check("ldac_arg_addr", 32'(im_addr), 32'h3);
        check("ldac_arg_valid", 32'(instr_valid), 32'h0);
        step(1);
        check("ldac_3cyc_valid", 32'(instr_valid), 32'h0);
        step(1);
        check_instr("ldac", OP_LDAC, 16'd7, 1'b1, 16'd2);
        step(1);
        check("ldac_next_pc", 32'(pc), 32'h4);

        // Back-pressure: ready low for five cycles in VALID.
        instr_ready = 1'b0;
        step(2);
        check_instr("hold0", 16'd10, 16'd0, 1'b0, 16'd4);
        for (int k = 0; k < 5; k++) begin
            step(1);
            check_instr("hold", 16'd10, 16'd0, 1'b0, 16'd4);
            check("hold_im_addr", 32'(im_addr), 32'h4);
        end
        instr_ready = 1'b1;
        step(1);
        check("hold_release_pc", 32'(pc), 32'h5);
        check("hold_release_valid", 32'(instr_valid), 32'h0);

        // Redirect during ARG_RSP of JPNZ, then ENDOP at 216.
        step(3);
        check("jpnz_state_arg_rsp", 32'(state_dbg), 32'(ARG_RSP));
        redirect = 1'b1;
        redirect_pc = 16'd216;
        step(1);
        redirect = 1'b0;
        check("redir_state", 32'(state_dbg), 32'(OP_REQ));
        check("redir_im_addr", 32'(im_addr), 32'd216);
        check("redir_operand_dropped", 32'(operand), 32'h0);
        check("redir_valid", 32'(instr_valid), 32'h0);
        step(2);
        check_instr("endop", OP_ENDOP, 16'd0, 1'b0, 16'd216);
        step(1);
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_pc", 32'(pc), 32'd216);
`ifdef FETCH_PERF_CNT_EN
        check("halt_fetch_count", fetch_count, 32'd5);
`endif
        redirect = 1'b1;
        redirect_pc = 16'd40;
        step(3);
        redirect = 1'b0;
        check("halt_redirect_state", 32'(state_dbg), 32'(HALT));
        check("halt_redirect_pc", 32'(pc), 32'd216);
        check("halt_redirect_im_addr", 32'(im_addr), 32'd216);
        check("halt_redirect_valid", 32'(instr_valid), 32'h0);
        check("sb_queue_drained_1", 32'(exp_q.size()), 32'h0);

        // Immediate asynchronous reset out of HALT.
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_halt");
        step(1);
        rst_n = 1'b1;

        // LDAC at 16'hFFFF: operand word comes from 16'h0000.
        exp_q.push_back(OP_LDAC);
        start = 1'b1;
        step(1);
        start = 1'b0;
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        step(1);
        redirect = 1'b0;
        check("wrap_req_pc", 32'(pc), 32'hFFFF);
        step(2);
        check("wrap_arg_addr", 32'(im_addr), 32'h0000);
        step(2);
        check_instr("wrap", OP_LDAC, 16'd64, 1'b1, 16'hFFFF);
        step(1);
        check("wrap_next_pc", 32'(pc), 32'h0001);

        // Reset during OP_RSP; late response must not be captured.
        step(1);
        check("midrst_state_op_rsp", 32'(state_dbg), 32'(OP_RSP));
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        step(1);
        rst_n = 1'b1;
        step(3);
        check("midrst_idle", 32'(state_dbg), 32'(IDLE));
        check("midrst_opcode", 32'(opcode), 32'h0);
        check("midrst_valid", 32'(instr_valid), 32'h0);

        // Resume only after a fresh start.
        exp_q.push_back(16'd64);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("resume_pc", 32'(pc), 32'h0);
        step(2);
        check_instr("resume", 16'd64, 16'd0, 1'b0, 16'd0);
        step(1);
        instr_ready = 1'b0;
        check("sb_queue_drained_2", 32'(exp_q.size()), 32'h0);
        step(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
